// File: rtl/stopwatch_cu_multi.sv
// Multi-channel stopwatch control unit: shared debounced buttons, per-channel Moore FSMs
// with lap hold and a programmable clear pulse length.

module stopwatch_cu_ch #(
   parameter int CLEAR_CYCLES = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic ev_run_i,
   input  logic ev_lap_i,
   input  logic ev_clear_i,
   output logic run_o,
   output logic lap_o,
   output logic clear_o
);
   localparam int CNT_W = 8;

   typedef enum logic [1:0] {
      ST_STOP  = 2'd0,
      ST_RUN   = 2'd1,
      ST_LAP   = 2'd2,
      ST_CLEAR = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               run_q, lap_q, clear_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_STOP: begin
            if (ev_run_i) begin
               state_d = ST_RUN;
            end else if (ev_clear_i) begin
               state_d = ST_CLEAR;
               cnt_d   = CNT_W'(CLEAR_CYCLES - 1);
            end
         end
         ST_RUN: begin
            if (ev_run_i)      state_d = ST_STOP;
            else if (ev_lap_i) state_d = ST_LAP;
         end
         ST_LAP: begin
            if (ev_run_i)      state_d = ST_STOP;
            else if (ev_lap_i) state_d = ST_RUN;
         end
         ST_CLEAR: begin
            // Counter runs to completion regardless of buttons or mode.
            if (cnt_q == '0) state_d = ST_STOP;
            else             cnt_d   = cnt_q - 1'b1;
         end
         default: state_d = ST_STOP;
      endcase
   end

   // Outputs are decoded from next state so they line up with the registered state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_STOP;
         cnt_q   <= '0;
         run_q   <= 1'b0;
         lap_q   <= 1'b0;
         clear_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         run_q   <= (state_d == ST_RUN) || (state_d == ST_LAP);
         lap_q   <= (state_d == ST_LAP);
         clear_q <= (state_d == ST_CLEAR);
      end
   end

   assign run_o   = run_q;
   assign lap_o   = lap_q;
   assign clear_o = clear_q;
endmodule

module stopwatch_cu_multi #(
   parameter int NUM_CH       = 4,
   parameter int CH_W         = 2,
   parameter int CLEAR_CYCLES = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              mode,
   input  logic [CH_W-1:0]   i_ch_sel,
   input  logic              i_btn_run,
   input  logic              i_btn_clear,
   input  logic              i_btn_lap,
   output logic [NUM_CH-1:0] o_run,
   output logic [NUM_CH-1:0] o_clear,
   output logic [NUM_CH-1:0] o_lap,
   output logic              o_any_run
);
   logic btn_run_q, btn_clear_q, btn_lap_q;
   logic ev_run, ev_clear, ev_lap, ev_en;

   // History samples every cycle in both modes, so a held button never re-fires.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         btn_run_q   <= 1'b0;
         btn_clear_q <= 1'b0;
         btn_lap_q   <= 1'b0;
      end else begin
         btn_run_q   <= i_btn_run;
         btn_clear_q <= i_btn_clear;
         btn_lap_q   <= i_btn_lap;
      end
   end

   assign ev_en    = ~mode && (int'(i_ch_sel) < NUM_CH);
   assign ev_run   = i_btn_run   & ~btn_run_q   & ev_en;
   assign ev_clear = i_btn_clear & ~btn_clear_q & ev_en;
   assign ev_lap   = i_btn_lap   & ~btn_lap_q   & ev_en;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      logic sel;
      assign sel = (i_ch_sel == CH_W'(g));

      stopwatch_cu_ch #(
         .CLEAR_CYCLES (CLEAR_CYCLES)
      ) u_ch (
         .clk        (clk),
         .reset      (reset),
         .ev_run_i   (ev_run & sel),
         .ev_lap_i   (ev_lap & sel),
         .ev_clear_i (ev_clear & sel),
         .run_o      (o_run[g]),
         .lap_o      (o_lap[g]),
         .clear_o    (o_clear[g])
      );
   end

   assign o_any_run = |o_run;
endmodule

// File: tb/tb_stopwatch_cu_multi.sv
// Directed bench for stopwatch_cu_multi with 3 channels and a 3-cycle clear pulse.

module tb_stopwatch_cu_multi;
   localparam int NUM_CH = 3;
   localparam int CH_W   = 2;
   localparam int CLR    = 3;

   logic              clk = 1'b0;
   logic              reset;
   logic              mode;
   logic [CH_W-1:0]   i_ch_sel;
   logic              i_btn_run, i_btn_clear, i_btn_lap;
   logic [NUM_CH-1:0] o_run, o_clear, o_lap;
   logic              o_any_run;

   int tests = 0;
   int fails = 0;

   stopwatch_cu_multi #(
      .NUM_CH       (NUM_CH),
      .CH_W         (CH_W),
      .CLEAR_CYCLES (CLR)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .mode        (mode),
      .i_ch_sel    (i_ch_sel),
      .i_btn_run   (i_btn_run),
      .i_btn_clear (i_btn_clear),
      .i_btn_lap   (i_btn_lap),
      .o_run       (o_run),
      .o_clear     (o_clear),
      .o_lap       (o_lap),
      .o_any_run   (o_any_run)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [NUM_CH-1:0] got, input logic [NUM_CH-1:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %b expected %b", name, got, exp);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; mode = 1'b0; i_ch_sel = '0;
      i_btn_run = 1'b0; i_btn_clear = 1'b0; i_btn_lap = 1'b0;
      tick(2);
      chk("reset_run", o_run, 3'b000);
      chk("reset_clear", o_clear, 3'b000);
      chk("reset_lap", o_lap, 3'b000);
      tests++;
      if (o_any_run !== 1'b0) begin
         fails++;
         $display("FAIL reset_any_run: got %b expected 0", o_any_run);
      end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_run_toggle();
      i_ch_sel = 2'd0;
      i_btn_run = 1'b1; tick();
      chk("run_ch0_press", o_run, 3'b001);
      tests++;
      if (o_any_run !== 1'b1) begin
         fails++;
         $display("FAIL run_any_run: got %b expected 1", o_any_run);
      end
      tick(4);
      chk("run_ch0_held", o_run, 3'b001);
      i_btn_run = 1'b0; tick();
      i_btn_run = 1'b1; tick();
      chk("run_ch0_stop", o_run, 3'b000);
      i_btn_run = 1'b0; tick();
   endtask

   task automatic test_lap();
      i_ch_sel = 2'd2;
      i_btn_run = 1'b1; tick(); i_btn_run = 1'b0;
      chk("lap_run_ch2", o_run, 3'b100);
      tick();
      i_btn_lap = 1'b1; tick(); i_btn_lap = 1'b0;
      chk("lap_enter_lap", o_lap, 3'b100);
      chk("lap_enter_run", o_run, 3'b100);
      tick();
      i_btn_lap = 1'b1; tick(); i_btn_lap = 1'b0;
      chk("lap_exit_lap", o_lap, 3'b000);
      chk("lap_exit_run", o_run, 3'b100);
      tick();
      i_btn_lap = 1'b1; tick(); i_btn_lap = 1'b0; tick();
      i_btn_run = 1'b1; tick(); i_btn_run = 1'b0;
      chk("lap_stop_run", o_run, 3'b000);
      chk("lap_stop_lap", o_lap, 3'b000);
      tick();
   endtask

   task automatic test_clear();
      i_ch_sel = 2'd1;
      i_btn_clear = 1'b1; tick();
      chk("clr_cyc1", o_clear, 3'b010);
      i_btn_run = 1'b1; tick();
      chk("clr_cyc2", o_clear, 3'b010);
      chk("clr_run_ignored", o_run, 3'b000);
      tick();
      chk("clr_cyc3", o_clear, 3'b010);
      tick();
      chk("clr_done", o_clear, 3'b000);
      chk("clr_stop", o_run, 3'b000);
      i_btn_run = 1'b0; i_btn_clear = 1'b0; tick();
      i_btn_run = 1'b1; tick(); i_btn_run = 1'b0; tick();
      i_btn_clear = 1'b1; tick(); i_btn_clear = 1'b0;
      chk("clr_in_run_clear", o_clear, 3'b000);
      chk("clr_in_run_run", o_run, 3'b010);
      tick();
      i_btn_run = 1'b1; tick(); i_btn_run = 1'b0;
      chk("clr_ch1_stopped", o_run, 3'b000);
      tick();
   endtask

   task automatic test_simultaneous();
      i_ch_sel = 2'd2;
      i_btn_run = 1'b1; i_btn_clear = 1'b1; tick();
      i_btn_run = 1'b0; i_btn_clear = 1'b0;
      chk("sim_run_clear_run", o_run, 3'b100);
      chk("sim_run_clear_clr", o_clear, 3'b000);
      tick();
      i_btn_run = 1'b1; i_btn_lap = 1'b1; tick();
      i_btn_run = 1'b0; i_btn_lap = 1'b0;
      chk("sim_run_lap_run", o_run, 3'b000);
      chk("sim_run_lap_lap", o_lap, 3'b000);
      tick();
   endtask

   task automatic test_gating();
      mode = 1'b1; i_ch_sel = 2'd0;
      i_btn_run = 1'b1; tick();
      chk("gate_watch_mode", o_run, 3'b000);
      mode = 1'b0; tick();
      chk("gate_mode_held", o_run, 3'b000);
      i_btn_run = 1'b0; tick();
      i_btn_run = 1'b1; tick();
      chk("gate_mode_press", o_run, 3'b001);
      i_ch_sel = 2'd1; tick();
      chk("gate_sel_held", o_run, 3'b001);
      i_btn_run = 1'b0; i_ch_sel = 2'd0; tick();
      i_btn_run = 1'b1; tick(); i_btn_run = 1'b0;
      chk("gate_ch0_off", o_run, 3'b000);
      tick();
      i_ch_sel = 2'd3;
      i_btn_run = 1'b1; tick(); i_btn_run = 1'b0; tick();
      chk("gate_oor_run", o_run, 3'b000);
      i_btn_clear = 1'b1; tick(); i_btn_clear = 1'b0;
      chk("gate_oor_clear", o_clear, 3'b000);
      tick();
   endtask

   task automatic test_reset_mid();
      i_ch_sel = 2'd0; i_btn_run = 1'b1; tick(); i_btn_run = 1'b0; tick();
      i_ch_sel = 2'd1; i_btn_run = 1'b1; tick(); i_btn_run = 1'b0; tick();
      i_ch_sel = 2'd2; i_btn_clear = 1'b1; tick(); i_btn_clear = 1'b0;
      chk("mid_pre_run", o_run, 3'b011);
      chk("mid_pre_clear", o_clear, 3'b100);
      #2 reset = 1'b1;
      #1;
      chk("mid_async_run", o_run, 3'b000);
      chk("mid_async_clear", o_clear, 3'b000);
      tests++;
      if (o_any_run !== 1'b0) begin
         fails++;
         $display("FAIL mid_any_run: got %b expected 0", o_any_run);
      end
      // Button held across reset release fires on the first clock.
      i_ch_sel = 2'd0; i_btn_run = 1'b1;
      tick();
      reset = 1'b0;
      tick();
      chk("rel_held_fires", o_run, 3'b001);
      chk("rel_clear_idle", o_clear, 3'b000);
      i_btn_run = 1'b0; tick();
   endtask

   initial begin
      test_reset();
      test_run_toggle();
      test_lap();
      test_clear();
      test_simultaneous();
      test_gating();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
